// File: rtl/axi_pkg.sv
// Shared types and constants for the AXI4-Lite SRAM responder.
// Also holds the seed of the optional random-delay LFSR.
package axi_pkg;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } read_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT,
    W_RESP
  } write_state_t;

  localparam logic       RESP_OKAY = 1'b0;
  localparam logic       RESP_ERR  = 1'b1;
  localparam logic [3:0] LFSR_SEED = 4'b1001;

endpackage

// File: rtl/axi_delay_lfsr.sv
// Free-running 4-bit Fibonacci LFSR (x^4+x^3+1) used as a per-transaction response delay.
// Maximal length, so it cycles through 1..15 and never reaches zero.
module axi_delay_lfsr
  import axi_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] out
);

  logic [3:0] lfsr_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_reg <= LFSR_SEED;
    end else begin
      lfsr_reg <= {lfsr_reg[2:0], lfsr_reg[3] ^ lfsr_reg[2]};
    end
  end

  assign out = lfsr_reg;

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4-Lite responder over an inline word-addressed SRAM with independent read/write FSMs.
// Define AXI_RAND_DELAY_EN to draw each response delay from an LFSR instead of LATENCY.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int          DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic        rresp,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [7:0]  wmask,
  output logic        bvalid,
  input  logic        bready,
  output logic        bresp
);

  localparam int          IDX_W = $clog2(DEPTH);
  localparam logic [31:0] SPAN  = 32'(4 * DEPTH);

  logic [31:0] mem [DEPTH];

  logic [3:0] delay;
`ifdef AXI_RAND_DELAY_EN
  logic [3:0] lfsr_out;

  axi_delay_lfsr u_delay_lfsr (
    .clk   (clk),
    .reset (reset),
    .out   (lfsr_out)
  );

  assign delay = lfsr_out;
`else
  assign delay = 4'(LATENCY);
`endif

  // Unsigned offset from BASE: anything below BASE wraps to a huge value,
  // so a single compare covers both range bounds.
  logic [31:0] ar_off, aw_off;
  logic        ar_in_range, aw_in_range;

  assign ar_off      = araddr - BASE;
  assign aw_off      = awaddr - BASE;
  assign ar_in_range = (ar_off < SPAN);
  assign aw_in_range = (aw_off < SPAN);

  logic unused_wmask_hi;
  assign unused_wmask_hi = &{1'b0, wmask[7:4]};

  // ---------------- read channel ----------------
  read_state_t      r_state_reg, r_state_next;
  logic [3:0]       r_cnt_reg;
  logic [IDX_W-1:0] r_idx_reg;
  logic             r_ok_reg;
  logic [31:0]      rdata_reg;
  logic             rresp_reg;
  logic             ar_hs;

  assign ar_hs = arvalid && arready;

  always_comb begin
    r_state_next = r_state_reg;
    arready      = 1'b0;
    rvalid       = 1'b0;
    case (r_state_reg)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) r_state_next = R_WAIT;
      end
      R_WAIT: begin
        if (r_cnt_reg == 4'd0) r_state_next = R_RESP;
      end
      R_RESP: begin
        rvalid = 1'b1;
        if (rready) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_reg <= R_IDLE;
      r_cnt_reg   <= 4'd0;
      r_idx_reg   <= '0;
      r_ok_reg    <= 1'b0;
      rdata_reg   <= 32'd0;
      rresp_reg   <= RESP_OKAY;
    end else begin
      r_state_reg <= r_state_next;
      case (r_state_reg)
        R_IDLE: begin
          if (ar_hs) begin
            r_idx_reg <= ar_off[IDX_W+1:2];
            r_ok_reg  <= ar_in_range;
            r_cnt_reg <= delay;
          end
        end
        R_WAIT: begin
          if (r_cnt_reg == 4'd0) begin
            rdata_reg <= r_ok_reg ? mem[r_idx_reg] : 32'd0;
            rresp_reg <= r_ok_reg ? RESP_OKAY : RESP_ERR;
          end else begin
            r_cnt_reg <= r_cnt_reg - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rdata = rdata_reg;
  assign rresp = rresp_reg;

  // ---------------- write channel ----------------
  write_state_t     w_state_reg, w_state_next;
  logic [3:0]       w_cnt_reg;
  logic             aw_got_reg, w_got_reg;
  logic [IDX_W-1:0] w_idx_reg;
  logic             w_ok_reg;
  logic [31:0]      w_data_reg;
  logic [3:0]       w_mask_reg;
  logic             bresp_reg;
  logic             aw_hs, w_hs, mem_we;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  always_comb begin
    w_state_next = w_state_reg;
    awready      = 1'b0;
    wready       = 1'b0;
    bvalid       = 1'b0;
    case (w_state_reg)
      W_IDLE: begin
        awready = !aw_got_reg;
        wready  = !w_got_reg;
        if ((aw_got_reg || awvalid) && (w_got_reg || wvalid)) w_state_next = W_WAIT;
      end
      W_WAIT: begin
        if (w_cnt_reg == 4'd0) w_state_next = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_reg <= W_IDLE;
      w_cnt_reg   <= 4'd0;
      aw_got_reg  <= 1'b0;
      w_got_reg   <= 1'b0;
      w_idx_reg   <= '0;
      w_ok_reg    <= 1'b0;
      w_data_reg  <= 32'd0;
      w_mask_reg  <= 4'd0;
      bresp_reg   <= RESP_OKAY;
    end else begin
      w_state_reg <= w_state_next;
      case (w_state_reg)
        W_IDLE: begin
          if (aw_hs) begin
            aw_got_reg <= 1'b1;
            w_idx_reg  <= aw_off[IDX_W+1:2];
            w_ok_reg   <= aw_in_range;
          end
          if (w_hs) begin
            w_got_reg  <= 1'b1;
            w_data_reg <= wdata;
            w_mask_reg <= wmask[3:0];
          end
          if (w_state_next == W_WAIT) w_cnt_reg <= delay;
        end
        W_WAIT: begin
          if (w_cnt_reg == 4'd0) begin
            bresp_reg <= w_ok_reg ? RESP_OKAY : RESP_ERR;
          end else begin
            w_cnt_reg <= w_cnt_reg - 4'd1;
          end
        end
        W_RESP: begin
          if (bready) begin
            aw_got_reg <= 1'b0;
            w_got_reg  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bresp = bresp_reg;

  // Gated by reset so a transaction interrupted on its commit edge never lands.
  assign mem_we = !reset && (w_state_reg == W_WAIT) && (w_cnt_reg == 4'd0) && w_ok_reg;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_mask_reg[b]) mem[w_idx_reg][8*b +: 8] <= w_data_reg[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave (DEPTH=1024, BASE=0x8000_0000, LATENCY=2).
// Build with AXI_RAND_DELAY_EN defined to also exercise the random-delay mode.
module tb_axi_sram_slave;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        arvalid = 1'b0, arready;
  logic [31:0] araddr = 32'd0;
  logic        rvalid, rready = 1'b1;
  logic [31:0] rdata;
  logic        rresp;
  logic        awvalid = 1'b0, awready;
  logic [31:0] awaddr = 32'd0;
  logic        wvalid = 1'b0, wready;
  logic [31:0] wdata = 32'd0;
  logic [7:0]  wmask = 8'd0;
  logic        bvalid, bready = 1'b1;
  logic        bresp;

  int vectors = 0;
  int miscompares = 0;

  axi_sram_slave #(
    .DEPTH   (1024),
    .BASE    (32'h8000_0000),
    .LATENCY (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .arvalid (arvalid),
    .arready (arready),
    .araddr  (araddr),
    .rvalid  (rvalid),
    .rready  (rready),
    .rdata   (rdata),
    .rresp   (rresp),
    .awvalid (awvalid),
    .awready (awready),
    .awaddr  (awaddr),
    .wvalid  (wvalid),
    .wready  (wready),
    .wdata   (wdata),
    .wmask   (wmask),
    .bvalid  (bvalid),
    .bready  (bready),
    .bresp   (bresp)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // lat = clock edges from the AR handshake edge to the first cycle rvalid is seen.
  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic resp, output int lat);
    int n;
    @(negedge clk);
    arvalid = 1'b1;
    araddr  = addr;
    rready  = 1'b1;
    n = 0;
    while (!arready && n < 64) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    data = rdata;
    resp = rresp;
    $display("rd addr=%h data=%h resp=%0d lat=%0d", addr, data, resp, lat);
  endtask

  // order: 0 = AW and W together, 1 = W two cycles before AW, 2 = AW two cycles before W.
  // lat is counted from the handshake edge of the later channel.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [7:0] mask,
                          input int order, output logic resp, output int lat);
    @(negedge clk);
    if (order != 2) begin
      wvalid = 1'b1; wdata = data; wmask = mask;
    end
    if (order != 1) begin
      awvalid = 1'b1; awaddr = addr;
    end
    if (order != 0) begin
      @(negedge clk);
      wvalid  = 1'b0;
      awvalid = 1'b0;
      @(negedge clk);
      if (order == 1) begin
        awvalid = 1'b1; awaddr = addr;
      end else begin
        wvalid = 1'b1; wdata = data; wmask = mask;
      end
    end
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    lat = 0;
    while (!bvalid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    resp = bresp;
    $display("wr addr=%h data=%h mask=%h order=%0d resp=%0d lat=%0d", addr, data, mask, order, resp, lat);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++; if (arready !== 1'b1) begin miscompares++; $display("FAIL reset_arready: got %b want 1", arready); end
    vectors++; if (awready !== 1'b1) begin miscompares++; $display("FAIL reset_awready: got %b want 1", awready); end
    vectors++; if (wready !== 1'b1) begin miscompares++; $display("FAIL reset_wready: got %b want 1", wready); end
    vectors++; if (rvalid !== 1'b0) begin miscompares++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
    vectors++; if (bvalid !== 1'b0) begin miscompares++; $display("FAIL reset_bvalid: got %b want 0", bvalid); end
    vectors++; if (rdata !== 32'd0) begin miscompares++; $display("FAIL reset_rdata: got %h want 00000000", rdata); end
    vectors++; if (rresp !== 1'b0 || bresp !== 1'b0) begin
      miscompares++; $display("FAIL reset_resp: got rresp=%b bresp=%b want 0/0", rresp, bresp);
    end
  endtask

  task automatic test_read_basic();
    logic [31:0] d;
    logic        r;
    int          lat;
    do_write(32'h8000_0000, 32'hDEAD_BEEF, 8'h0F, 0, r, lat);
    vectors++; if (r !== 1'b0) begin miscompares++; $display("FAIL wr0_bresp: got %b want 0", r); end
    do_read(32'h8000_0000, d, r, lat);
`ifdef AXI_RAND_DELAY_EN
    vectors++; if (lat < 1 || lat > 16) begin miscompares++; $display("FAIL rd0_latency: got %0d want 1..16", lat); end
`else
    vectors++; if (lat != 3) begin miscompares++; $display("FAIL rd0_latency: got %0d want 3", lat); end
`endif
    vectors++; if (d !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rd0_data: got %h want deadbeef", d); end
    vectors++; if (r !== 1'b0) begin miscompares++; $display("FAIL rd0_rresp: got %b want 0", r); end
  endtask

  task automatic test_write_order_mask();
    logic [31:0] d;
    logic        r;
    int          lat;
    do_write(32'h8000_0004, 32'hAABB_CCDD, 8'h0F, 0, r, lat);
    do_write(32'h8000_0004, 32'h1122_3344, 8'h05, 1, r, lat);
`ifdef AXI_RAND_DELAY_EN
    vectors++; if (lat < 1 || lat > 16) begin miscompares++; $display("FAIL wsplit_latency: got %0d want 1..16", lat); end
`else
    vectors++; if (lat != 3) begin miscompares++; $display("FAIL wsplit_latency: got %0d want 3", lat); end
`endif
    vectors++; if (r !== 1'b0) begin miscompares++; $display("FAIL wsplit_bresp: got %b want 0", r); end
    do_read(32'h8000_0004, d, r, lat);
    vectors++; if (d !== 32'hAA22_CC44) begin miscompares++; $display("FAIL wsplit_data: got %h want aa22cc44", d); end
    // AW first, upper mask bits set but ignored
    do_write(32'h8000_0008, 32'h0102_0304, 8'h0F, 0, r, lat);
    do_write(32'h8000_0008, 32'hA0B0_C0D0, 8'hFA, 2, r, lat);
    vectors++; if (r !== 1'b0) begin miscompares++; $display("FAIL awfirst_bresp: got %b want 0", r); end
    do_read(32'h8000_0008, d, r, lat);
    vectors++; if (d !== 32'hA002_C004) begin miscompares++; $display("FAIL awfirst_data: got %h want a002c004", d); end
    do_write(32'h8000_0008, 32'hFFFF_FFFF, 8'h00, 0, r, lat);
    vectors++; if (r !== 1'b0) begin miscompares++; $display("FAIL mask0_bresp: got %b want 0", r); end
    // unaligned byte address reads the same word
    do_read(32'h8000_000B, d, r, lat);
    vectors++; if (d !== 32'hA002_C004) begin miscompares++; $display("FAIL mask0_data: got %h want a002c004", d); end
    do_write(32'h8000_0FFC, 32'h1357_9BDF, 8'h0F, 0, r, lat);
    do_read(32'h8000_0FFC, d, r, lat);
    vectors++; if (d !== 32'h1357_9BDF || r !== 1'b0) begin
      miscompares++; $display("FAIL last_word: got %h resp %b want 13579bdf resp 0", d, r);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d;
    logic        r;
    int          lat;
    do_read(32'h7FFF_FFFC, d, r, lat);
    vectors++; if (r !== 1'b1) begin miscompares++; $display("FAIL oor_rresp: got %b want 1", r); end
    vectors++; if (d !== 32'd0) begin miscompares++; $display("FAIL oor_rdata: got %h want 00000000", d); end
    do_write(32'h8000_1000, 32'hFFFF_FFFF, 8'h0F, 0, r, lat);
    vectors++; if (r !== 1'b1) begin miscompares++; $display("FAIL oor_bresp: got %b want 1", r); end
    do_read(32'h8000_0000, d, r, lat);
    vectors++; if (d !== 32'hDEAD_BEEF || r !== 1'b0) begin
      miscompares++; $display("FAIL oor_mem_intact: got %h resp %b want deadbeef resp 0", d, r);
    end
  endtask

  task automatic test_rready_stall();
    int n;
    logic [31:0] held;
    @(negedge clk);
    rready  = 1'b0;
    arvalid = 1'b1;
    araddr  = 32'h8000_0004;
    @(posedge clk);
    @(negedge clk);
    araddr = 32'h8000_0000;
    n = 0;
    while (!rvalid && n < 64) begin
      @(negedge clk);
      n++;
    end
    held = 32'hAA22_CC44;
    for (int i = 0; i < 5; i++) begin
      vectors++; if (rvalid !== 1'b1 || rdata !== held || arready !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_cycle%0d: got rvalid=%b rdata=%h arready=%b want 1 %h 0", i, rvalid, rdata, arready, held);
      end
      @(negedge clk);
    end
    $display("rd addr=80000004 data=%h stalled 5 cycles", rdata);
    rready = 1'b1;
    @(negedge clk);
    vectors++; if (arready !== 1'b1 || rvalid !== 1'b0) begin
      miscompares++; $display("FAIL stall_release: got arready=%b rvalid=%b want 1 0", arready, rvalid);
    end
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 64) begin
      @(negedge clk);
      n++;
    end
    $display("rd addr=80000000 data=%h resp=%0d (queued AR)", rdata, rresp);
    vectors++; if (rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL stall_next_ar: got %h want deadbeef", rdata); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic        r;
    int          lat;
    @(negedge clk);
    arvalid = 1'b1; araddr = 32'h8000_0000;
    awvalid = 1'b1; awaddr = 32'h8000_0004;
    wvalid  = 1'b1; wdata  = 32'h0000_0000; wmask = 8'h0F;
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++; if (rvalid !== 1'b0 || bvalid !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_valid: got rvalid=%b bvalid=%b want 0 0", rvalid, bvalid);
    end
    vectors++; if (arready !== 1'b1 || awready !== 1'b1 || wready !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_ready: got ar=%b aw=%b w=%b want 1 1 1", arready, awready, wready);
    end
    repeat (6) @(negedge clk);
    vectors++; if (rvalid !== 1'b0 || bvalid !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_dropped: got rvalid=%b bvalid=%b want 0 0", rvalid, bvalid);
    end
    $display("rst mid-transaction applied");
    do_read(32'h8000_0004, d, r, lat);
    vectors++; if (d !== 32'hAA22_CC44) begin miscompares++; $display("FAIL rstmid_mem: got %h want aa22cc44", d); end
  endtask

`ifdef AXI_RAND_DELAY_EN
  task automatic test_rand_delay();
    logic [31:0] exp_tab [3];
    logic [31:0] d;
    logic        r;
    int          lat;
    int          distinct;
    bit          seen [17];
    exp_tab[0] = 32'hDEAD_BEEF;
    exp_tab[1] = 32'hAA22_CC44;
    exp_tab[2] = 32'hA002_C004;
    for (int i = 0; i < 17; i++) seen[i] = 1'b0;
    for (int i = 0; i < 100; i++) begin
      do_read(32'h8000_0000 + 32'(4 * (i % 3)), d, r, lat);
      vectors++; if (lat < 1 || lat > 16 || d !== exp_tab[i % 3]) begin
        miscompares++; $display("FAIL rand_rd%0d: got lat=%0d data=%h want 1..16 %h", i, lat, d, exp_tab[i % 3]);
      end
      if (lat >= 1 && lat <= 16) seen[lat] = 1'b1;
    end
    distinct = 0;
    for (int i = 0; i < 17; i++) if (seen[i]) distinct++;
    vectors++; if (distinct < 2) begin miscompares++; $display("FAIL rand_distinct: got %0d want >=2", distinct); end
  endtask
`endif

  initial begin
    test_reset();
    test_read_basic();
    test_write_order_mask();
    test_out_of_range();
    test_rready_stall();
    test_reset_mid();
`ifdef AXI_RAND_DELAY_EN
    test_rand_delay();
`endif
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
